apb_master_bridge: RTL and testbench
====================================

// Module: apb_master_bridge
// PURPOSE
//  Single-outstanding APB master: accepts a simple valid/ready request from the local bus, runs
//  APB SETUP/ACCESS phases, waits for PREADY and returns a one-cycle response.
//  Sits directly upstream of the APB RAM slaves and drives their PSEL/PENABLE/PADDR/PWDATA/PWRITE.
//  The address MSB selects one of two slaves: PSEL1 or PSEL2.
// PARAMETERS
//  ADDRESS  8   APB address width; bit ADDRESS-1 selects the slave
//  DATA     8   APB read/write data width
//  TIMEOUT  16  ACCESS cycles without PREADY before abort (used only with APB_TIMEOUT_EN)
// PORTS
//  PCLK       in   1        APB clock
//  PRESETn    in   1        asynchronous, active-low reset
//  req_valid  in   1        request present
//  req_ready  out  1        bridge accepts the request this cycle
//  req_write  in   1        1=write, 0=read
//  req_addr   in   ADDRESS  transfer address
//  req_wdata  in   DATA     write data
//  rsp_valid  out  1        one-cycle completion pulse
//  rsp_rdata  out  DATA     read data, valid with rsp_valid; 0 for writes
//  rsp_err    out  1        transfer aborted by timeout, valid with rsp_valid
//  PSEL1      out  1        slave 1 select (req_addr[ADDRESS-1]==0)
//  PSEL2      out  1        slave 2 select (req_addr[ADDRESS-1]==1)
//  PENABLE    out  1        APB access phase
//  PWRITE     out  1        APB direction
//  PADDR      out  ADDRESS  APB address, full width, MSB included
//  PWDATA     out  DATA     APB write data
//  PRDATA     in   DATA     read data from selected slave (slave outputs are pre-muxed externally)
//  PREADY     in   1        transfer-complete from selected slave
// BEHAVIOUR
//  Reset: state=IDLE; req_ready=1; rsp_valid=0; rsp_err=0; rsp_rdata=0; PSEL1/PSEL2=0; PENABLE=0;
//    PWRITE=0; PADDR=0; PWDATA=0. Registered outputs only; no combinational path from req_* to APB.
//  FSM: IDLE -> SETUP -> ACCESS -> IDLE.
//  IDLE: req_ready=1. On req_valid, latch write/addr/wdata into PWRITE/PADDR/PWDATA; go to SETUP.
//  SETUP: exactly 1 cycle. Decoded PSELx=1, PENABLE=0, req_ready=0. Go to ACCESS.
//  ACCESS: PSELx=1, PENABLE=1. PADDR/PWDATA/PWRITE held stable until exit.
//  ACCESS with PREADY=1: next cycle rsp_valid=1, rsp_rdata=PRDATA (reads) or 0 (writes),
//    rsp_err=0; PSELx/PENABLE drop to 0; state IDLE.
//  ACCESS with PREADY=0: stay in ACCESS.
//  Latency: req accept at cycle 0 -> SETUP c1 -> ACCESS c2. With the RAM slave, PREADY is seen
//    in c3 and rsp_valid is asserted in c4. Next accept at c4 at the earliest.
//  Exactly one PSELx is high outside IDLE; both are low in IDLE.
//  rsp_valid is high for one cycle and is never asserted in the same cycle as PSELx.
//  req_valid asserted outside IDLE is ignored (req_ready=0); the requester holds it until accepted.
//  Reset mid-transfer: all outputs return to reset values immediately; no response is issued
//    for the aborted transfer.
// CONFIGURATION
//  APB_TIMEOUT_EN defined: a counter of width $clog2(TIMEOUT+1) clears on entry to ACCESS and
//    increments each ACCESS cycle with PREADY=0. When it reaches TIMEOUT, next cycle:
//    PSELx/PENABLE=0, rsp_valid=1, rsp_err=1, rsp_rdata=0, state IDLE.
//    If PREADY=1 arrives in the same cycle as the terminal count, PREADY wins and rsp_err=0.
//  APB_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely; rsp_err is tied to 0.
// STRUCTURE
//  apb_pkg: state enum {IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10}, default widths ADDRESS/DATA,
//    and a shared APB phase typedef for the slaves.
//  Sub-module apb_addr_decoder: PADDR MSB plus active flag -> PSEL1/PSEL2 (combinational,
//    registered in the parent).
// TESTING
//  Write 0x05 to addr 0x12 against RAM slave -> PSEL1=1 c1-c3, PENABLE=1 c2-c3, rsp_valid c4,
//    rsp_err=0, RAM[0x12]=0x05.
//  Read addr 0x12 after the write -> rsp_valid with rsp_rdata=0x05; PSEL2 never asserted.
//  Addr 0x92 -> PSEL2=1 and PSEL1=0 for the whole transfer.
//  Slave holds PREADY=0 for 5 ACCESS cycles -> PADDR/PWDATA stable; rsp_valid one cycle after PREADY.
//  APB_TIMEOUT_EN, TIMEOUT=4, PREADY stuck 0 -> abort after 4 ACCESS cycles: rsp_err=1,
//    rsp_rdata=0, PSEL low.
//  PRESETn asserted during ACCESS -> all outputs at reset values immediately, no rsp_valid;
//    next request completes normally.

Source files
------------

// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : apb_pkg
//  Description : Shared types and default widths for the APB master bridge
//                and the APB RAM slaves it drives.
//  Revision    : 1.0  initial release
// ============================================================================
package apb_pkg;

    // Default bus widths; the bridge and interface take these as defaults.
    localparam int APB_ADDR_W = 8;
    localparam int APB_DATA_W = 8;

    // Bridge sequencer states.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } state_t;

    // Bus phase as seen by a slave from its PSEL/PENABLE pair.
    typedef enum logic [1:0] {
        PHASE_IDLE    = 2'b00,
        PHASE_SETUP   = 2'b01,
        PHASE_ACCESS  = 2'b10,
        PHASE_INVALID = 2'b11
    } apb_phase_t;

    // Classify a slave's view of the bus; PENABLE without PSEL is illegal.
    function automatic apb_phase_t apb_phase(input logic psel, input logic penable);
        apb_phase_t ph;
        case ({psel, penable})
            2'b00:   ph = PHASE_IDLE;
            2'b10:   ph = PHASE_SETUP;
            2'b11:   ph = PHASE_ACCESS;
            default: ph = PHASE_INVALID;
        endcase
        return ph;
    endfunction

endpackage
`default_nettype wire

// File: rtl/apb_master_bridge_if.sv
`default_nettype none
// ============================================================================
//  Module      : apb_master_bridge_if
//  Description : Local request/response bus plus APB master-side signals of
//                the bridge. The master modport is the bridge itself; the
//                slave modport is its environment (requester + APB slaves,
//                whose PRDATA/PREADY arrive already muxed).
//  Revision    : 1.0  initial release
// ============================================================================
interface apb_master_bridge_if
    import apb_pkg::*;
#(
    parameter int ADDRESS = APB_ADDR_W,
    parameter int DATA    = APB_DATA_W
);

    // Local request side
    logic               req_valid;
    logic               req_ready;
    logic               req_write;
    logic [ADDRESS-1:0] req_addr;
    logic [DATA-1:0]    req_wdata;

    // Local response side
    logic               rsp_valid;
    logic [DATA-1:0]    rsp_rdata;
    logic               rsp_err;

    // APB side
    logic               PSEL1;
    logic               PSEL2;
    logic               PENABLE;
    logic               PWRITE;
    logic [ADDRESS-1:0] PADDR;
    logic [DATA-1:0]    PWDATA;
    logic [DATA-1:0]    PRDATA;
    logic               PREADY;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA
    );

endinterface
`default_nettype wire

// File: rtl/apb_addr_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : apb_addr_decoder
//  Description : Two-way APB slave select from the address MSB. Purely
//                combinational; the parent registers the selects.
//  Revision    : 1.0  initial release
// ============================================================================
module apb_addr_decoder (
    input  wire  addr_msb,
    input  wire  active,
    output logic psel1,
    output logic psel2
);

    // MSB low -> slave 1, MSB high -> slave 2; nothing selected when idle.
    always_comb begin
        psel1 = active & ~addr_msb;
        psel2 = active &  addr_msb;
    end

endmodule
`default_nettype wire

// File: rtl/apb_master_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : apb_master_bridge
//  Description : Single-outstanding APB master. Accepts one valid/ready
//                request, runs SETUP then ACCESS until PREADY, and returns
//                a one-cycle response. All bus outputs are registered.
//  Config      : APB_TIMEOUT_EN - abort ACCESS after TIMEOUT cycles without
//                PREADY and flag rsp_err. Undefined: wait forever, rsp_err=0.
//  Revision    : 1.0  initial release
// ============================================================================
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int ADDRESS = APB_ADDR_W,
    parameter int DATA    = APB_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  wire                 PCLK,
    input  wire                 PRESETn,
    apb_master_bridge_if.master bus
);

    state_t             r_state;
    state_t             w_state_next;
    logic [ADDRESS-1:0] r_paddr,     w_paddr_next;
    logic [DATA-1:0]    r_pwdata,    w_pwdata_next;
    logic               r_pwrite,    w_pwrite_next;
    logic               r_penable,   w_penable_next;
    logic               r_psel1,     w_psel1_next;
    logic               r_psel2,     w_psel2_next;
    logic               r_rsp_valid, w_rsp_valid_next;
    logic [DATA-1:0]    r_rsp_rdata, w_rsp_rdata_next;

`ifdef APB_TIMEOUT_EN
    localparam int                 c_CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_TERMINAL = c_CNT_W'(TIMEOUT);

    logic [c_CNT_W-1:0] r_cnt, w_cnt_next;
    logic               r_rsp_err, w_rsp_err_next;
`else
    // TIMEOUT only matters when the abort counter is built.
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
`endif

    // Selects are decoded from the next address/state so they can be
    // registered alongside PADDR and appear in the same cycle as SETUP.
    apb_addr_decoder u_decoder (
        .addr_msb (w_paddr_next[ADDRESS-1]),
        .active   (w_state_next != IDLE),
        .psel1    (w_psel1_next),
        .psel2    (w_psel2_next)
    );

    // Next-state and next-output logic for the SETUP/ACCESS sequence.
    always_comb begin
        w_state_next     = r_state;
        w_paddr_next     = r_paddr;
        w_pwdata_next    = r_pwdata;
        w_pwrite_next    = r_pwrite;
        w_penable_next   = 1'b0;
        w_rsp_valid_next = 1'b0;
        w_rsp_rdata_next = '0;
`ifdef APB_TIMEOUT_EN
        w_cnt_next       = r_cnt;
        w_rsp_err_next   = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (bus.req_valid) begin
                    w_paddr_next  = bus.req_addr;
                    w_pwdata_next = bus.req_wdata;
                    w_pwrite_next = bus.req_write;
                    w_state_next  = SETUP;
                end
            end
            SETUP: begin
                w_penable_next = 1'b1;
                w_state_next   = ACCESS;
`ifdef APB_TIMEOUT_EN
                w_cnt_next     = '0;
`endif
            end
            ACCESS: begin
                if (bus.PREADY) begin
                    // PREADY takes priority over a coincident terminal count.
                    w_state_next     = IDLE;
                    w_rsp_valid_next = 1'b1;
                    w_rsp_rdata_next = r_pwrite ? '0 : bus.PRDATA;
                end else begin
                    w_penable_next = 1'b1;
`ifdef APB_TIMEOUT_EN
                    w_cnt_next = r_cnt + 1'b1;
                    if (w_cnt_next == c_TERMINAL) begin
                        w_state_next     = IDLE;
                        w_penable_next   = 1'b0;
                        w_rsp_valid_next = 1'b1;
                        w_rsp_err_next   = 1'b1;
                    end
`endif
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // State and registered bus outputs; reset clears everything at once.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state     <= IDLE;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_pwrite    <= 1'b0;
            r_penable   <= 1'b0;
            r_psel1     <= 1'b0;
            r_psel2     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
`ifdef APB_TIMEOUT_EN
            r_cnt       <= '0;
            r_rsp_err   <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_next;
            r_paddr     <= w_paddr_next;
            r_pwdata    <= w_pwdata_next;
            r_pwrite    <= w_pwrite_next;
            r_penable   <= w_penable_next;
            r_psel1     <= w_psel1_next;
            r_psel2     <= w_psel2_next;
            r_rsp_valid <= w_rsp_valid_next;
            r_rsp_rdata <= w_rsp_rdata_next;
`ifdef APB_TIMEOUT_EN
            r_cnt       <= w_cnt_next;
            r_rsp_err   <= w_rsp_err_next;
`endif
        end
    end

    // Ready depends only on the state register, never on req_* directly.
    assign bus.req_ready = (r_state == IDLE);
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
`ifdef APB_TIMEOUT_EN
    assign bus.rsp_err   = r_rsp_err;
`else
    assign bus.rsp_err   = 1'b0;
`endif
    assign bus.PSEL1     = r_psel1;
    assign bus.PSEL2     = r_psel2;
    assign bus.PENABLE   = r_penable;
    assign bus.PWRITE    = r_pwrite;
    assign bus.PADDR     = r_paddr;
    assign bus.PWDATA    = r_pwdata;

endmodule
`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb_master_bridge
//  Description : Directed bench for apb_master_bridge with a RAM slave model
//                whose wait states are programmable per transfer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_apb_master_bridge;

    localparam int ADDRESS = 8;
    localparam int DATA    = 8;
    localparam int TIMEOUT = 4;

    logic PCLK    = 1'b0;
    logic PRESETn = 1'b0;

    apb_master_bridge_if #(.ADDRESS(ADDRESS), .DATA(DATA)) bus ();

    apb_master_bridge #(.ADDRESS(ADDRESS), .DATA(DATA), .TIMEOUT(TIMEOUT)) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .bus     (bus)
    );

    always #5 PCLK = ~PCLK;

    // RAM slave: PREADY rises after wait_n ACCESS cycles.
    logic [7:0] mem [0:255];
    int         wait_n = 1;
    int         acc;

    always @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)                                              acc <= 0;
        else if ((bus.PSEL1 | bus.PSEL2) & bus.PENABLE & ~bus.PREADY) acc <= acc + 1;
        else                                                       acc <= 0;
    end

    assign bus.PREADY = (bus.PSEL1 | bus.PSEL2) & bus.PENABLE & (acc >= wait_n);
    assign bus.PRDATA = mem[bus.PADDR];

    always @(posedge PCLK) begin
        if ((bus.PSEL1 | bus.PSEL2) & bus.PENABLE & bus.PREADY & bus.PWRITE)
            mem[bus.PADDR] <= bus.PWDATA;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " req_ready"}, bus.req_ready, 1);
        check({tag, " rsp_valid"}, bus.rsp_valid, 0);
        check({tag, " rsp_err"},   bus.rsp_err,   0);
        check({tag, " rsp_rdata"}, bus.rsp_rdata, 0);
        check({tag, " PSEL1"},     bus.PSEL1,     0);
        check({tag, " PSEL2"},     bus.PSEL2,     0);
        check({tag, " PENABLE"},   bus.PENABLE,   0);
        check({tag, " PWRITE"},    bus.PWRITE,    0);
        check({tag, " PADDR"},     bus.PADDR,     0);
        check({tag, " PWDATA"},    bus.PWDATA,    0);
    endtask

    // One transfer, called and returning at a negedge; lat counts cycles
    // after the accepting cycle (c0) until rsp_valid is seen, -1 on expiry.
    task automatic do_xfer(input logic wr, input logic [7:0] a, input logic [7:0] d,
                           input int waits, output int lat, output logic [7:0] rdata,
                           output logic err, output int np1, output int np2,
                           output int npen, output int unstable, output int overlap,
                           output int bad_ready);
        lat = -1; rdata = '0; err = 1'b0;
        np1 = 0; np2 = 0; npen = 0; unstable = 0; overlap = 0; bad_ready = 0;
        wait_n        = waits;
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = a;
        bus.req_wdata = d;
        for (int c = 1; c <= 60; c++) begin
            @(negedge PCLK);
            if (c == 1) bus.req_valid = 1'b0;
            if (bus.PSEL1 === 1'b1)   np1++;
            if (bus.PSEL2 === 1'b1)   np2++;
            if (bus.PENABLE === 1'b1) npen++;
            if ((bus.PSEL1 | bus.PSEL2) === 1'b1 &&
                (bus.PADDR !== a || bus.PWDATA !== d || bus.PWRITE !== wr))
                unstable++;
            if (bus.rsp_valid === 1'b1) begin
                lat   = c;
                rdata = bus.rsp_rdata;
                err   = bus.rsp_err;
                if ((bus.PSEL1 | bus.PSEL2) !== 1'b0) overlap++;
                if (bus.req_ready !== 1'b1)           bad_ready++;
                break;
            end
            if (bus.req_ready !== 1'b0) bad_ready++;
        end
    endtask

    typedef struct {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        int         waits;
        logic [7:0] exp_rdata;
        int         exp_psel1;
        int         exp_psel2;
        int         exp_pen;
        int         exp_lat;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int         lat, np1, np2, npen, unstable, overlap, bad_ready, cnt;
        logic [7:0] rdata;
        logic       err;

        //            wr    addr   wdata  wt  rdata  p1 p2 pen lat
        vecs[0] = '{1'b1, 8'h12, 8'h05, 1, 8'h00, 3, 0, 2, 4};
        vecs[1] = '{1'b0, 8'h12, 8'h00, 1, 8'h05, 3, 0, 2, 4};
        vecs[2] = '{1'b1, 8'h92, 8'hA7, 1, 8'h00, 0, 3, 2, 4};
        vecs[3] = '{1'b0, 8'h92, 8'h00, 1, 8'hA7, 0, 3, 2, 4};
        vecs[4] = '{1'b1, 8'h7F, 8'h3C, 5, 8'h00, 7, 0, 6, 8};
        vecs[5] = '{1'b0, 8'h7F, 8'h00, 0, 8'h3C, 2, 0, 1, 3};
        vecs[6] = '{1'b1, 8'h80, 8'hFF, 0, 8'h00, 0, 2, 1, 3};
        vecs[7] = '{1'b0, 8'h80, 8'h00, 2, 8'hFF, 0, 4, 3, 5};

        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;

        // Reset state
        repeat (3) @(negedge PCLK);
        check_reset_outputs("reset");
        PRESETn = 1'b1;
        @(negedge PCLK);

        // Table-driven transfers
        for (int i = 0; i < 8; i++) begin
            do_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].waits,
                    lat, rdata, err, np1, np2, npen, unstable, overlap, bad_ready);
            check($sformatf("v%0d latency", i),   lat,   vecs[i].exp_lat);
            check($sformatf("v%0d rsp_rdata", i), rdata, vecs[i].exp_rdata);
            check($sformatf("v%0d rsp_err", i),   err,   0);
            check($sformatf("v%0d PSEL1 cycles", i), np1, vecs[i].exp_psel1);
            check($sformatf("v%0d PSEL2 cycles", i), np2, vecs[i].exp_psel2);
            check($sformatf("v%0d PENABLE cycles", i), npen, vecs[i].exp_pen);
            check($sformatf("v%0d bus unstable", i), unstable, 0);
            check($sformatf("v%0d rsp with PSEL", i), overlap, 0);
            check($sformatf("v%0d req_ready wrong", i), bad_ready, 0);
        end
        check("ram[0x12]", mem[8'h12], 8'h05);
        check("ram[0x92]", mem[8'h92], 8'hA7);

        // rsp_valid is a single-cycle pulse
        @(negedge PCLK);
        check("rsp pulse width", bus.rsp_valid, 0);

        // Request held while busy: ignored until the bridge returns to IDLE
        wait_n        = 1;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 8'h20;
        bus.req_wdata = 8'h11;
        @(negedge PCLK);
        bus.req_addr  = 8'h21;
        bus.req_wdata = 8'h22;
        cnt = 0; lat = -1;
        for (int c = 1; c <= 20; c++) begin
            if ((bus.PSEL1 | bus.PSEL2) === 1'b1 && (bus.PADDR !== 8'h20 || bus.PWDATA !== 8'h11))
                cnt++;
            if (bus.rsp_valid === 1'b1) begin lat = c; break; end
            @(negedge PCLK);
        end
        check("held req: first PADDR stable", cnt, 0);
        check("held req: first latency", lat, 4);
        @(negedge PCLK);
        check("held req: second PADDR", bus.PADDR, 8'h21);
        check("held req: second PSEL1", bus.PSEL1, 1);
        check("held req: second PENABLE", bus.PENABLE, 0);
        bus.req_valid = 1'b0;
        lat = -1;
        for (int c = 2; c <= 20; c++) begin
            @(negedge PCLK);
            if (bus.rsp_valid === 1'b1) begin lat = c; break; end
        end
        check("held req: second latency", lat, 4);
        check("held req: ram[0x20]", mem[8'h20], 8'h11);
        check("held req: ram[0x21]", mem[8'h21], 8'h22);

        // Reset in the middle of ACCESS
        wait_n        = 1000;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 8'h12;
        bus.req_wdata = 8'h00;
        @(negedge PCLK);
        bus.req_valid = 1'b0;
        repeat (2) @(negedge PCLK);
        check("mid reset: in ACCESS", bus.PENABLE, 1);
        PRESETn = 1'b0;
        #1;
        check_reset_outputs("mid reset");
        repeat (2) @(negedge PCLK);
        PRESETn = 1'b1;
        wait_n  = 1;
        cnt = 0;
        repeat (5) begin
            @(negedge PCLK);
            if (bus.rsp_valid !== 1'b0) cnt++;
        end
        check("mid reset: no response", cnt, 0);
        do_xfer(1'b0, 8'h12, 8'h00, 1, lat, rdata, err, np1, np2, npen, unstable, overlap, bad_ready);
        check("post reset latency", lat, 4);
        check("post reset rdata", rdata, 8'h05);
        check("post reset PSEL1 cycles", np1, 3);

`ifdef APB_TIMEOUT_EN
        // PREADY stuck low: abort after TIMEOUT ACCESS cycles
        do_xfer(1'b0, 8'h12, 8'h00, 1000, lat, rdata, err, np1, np2, npen, unstable, overlap, bad_ready);
        check("timeout latency", lat, 6);
        check("timeout rsp_err", err, 1);
        check("timeout rsp_rdata", rdata, 0);
        check("timeout PSEL1 cycles", np1, 5);
        check("timeout PENABLE cycles", npen, 4);
        check("timeout rsp with PSEL", overlap, 0);
        // PREADY coincides with the terminal count: PREADY wins
        do_xfer(1'b0, 8'h12, 8'h00, 3, lat, rdata, err, np1, np2, npen, unstable, overlap, bad_ready);
        check("terminal PREADY latency", lat, 6);
        check("terminal PREADY rsp_err", err, 0);
        check("terminal PREADY rdata", rdata, 8'h05);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
